// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider entry controller.
package div_ctrl_pkg;

   localparam int unsigned NIB_W = 4;
   localparam int unsigned OP_W  = 8;
   localparam int unsigned RES_W = 7;

   typedef enum logic [3:0] {
      A_HI,
      A_LO,
      B_HI,
      B_LO,
      CHECK,
      START,
      WAIT,
      SHOW,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_DIV0 = 2'd1,
      ERR_OVF  = 2'd2,
      ERR_TMO  = 2'd3
   } err_t;

   // Quotient or remainder would not fit in RES_W bits.
   function automatic logic is_ovf(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      return a[OP_W-1] && ((b == OP_W'(1)) || (a < b));
   endfunction

endpackage

// File: rtl/div_entry_ctrl_if.sv
// Keypad, divider and display signals of the entry controller.
interface div_entry_ctrl_if;
   import div_ctrl_pkg::*;

   logic             key_valid;
   logic [NIB_W-1:0] key_code;
   logic             div_done;
   logic [RES_W-1:0] div_q;
   logic [RES_W-1:0] div_r;
   logic             div_start;
   logic [OP_W-1:0]  div_a;
   logic [OP_W-1:0]  div_b;
   logic [15:0]      disp_val;
   logic [3:0]       disp_en;
   logic             busy;
   logic             result_valid;
   logic [1:0]       err_code;

   // Controller side.
   modport master (
      input  key_valid, key_code, div_done, div_q, div_r,
      output div_start, div_a, div_b, disp_val, disp_en, busy, result_valid, err_code
   );

   // Environment side: keypad, divider and display.
   modport slave (
      output key_valid, key_code, div_done, div_q, div_r,
      input  div_start, div_a, div_b, disp_val, disp_en, busy, result_valid, err_code
   );

endinterface

// File: rtl/div_timeout_cnt.sv
// Counts WAIT cycles; expired flags the last allowed cycle without done.
module div_timeout_cnt #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   // Count while enabled, saturating at the last value.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/div_entry_ctrl.sv
// Keypad entry, operand screening and divider sequencing with display output.
module div_entry_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   div_entry_ctrl_if.master   bus
);

   state_t           state_q, state_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [RES_W-1:0] q_q, q_d;
   logic [RES_W-1:0] r_q, r_d;
   err_t             err_q, err_d;
   logic             start_q, busy_q, rv_q;
   logic             tmo_expired;

   div_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != WAIT),
      .en      ((state_q == WAIT) && !bus.div_done),
      .expired (tmo_expired)
   );

   // State, operand, result and state-decoded output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= A_HI;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         err_q   <= ERR_NONE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         r_q     <= r_d;
         err_q   <= err_d;
         start_q <= (state_d == START);
         busy_q  <= (state_d == CHECK) || (state_d == START) || (state_d == WAIT);
         rv_q    <= (state_d == SHOW);
      end
   end

   // Next-state, nibble capture, operand screening and result latching.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      r_d     = r_q;
      err_d   = err_q;
      unique case (state_q)
         A_HI: if (bus.key_valid) begin
            a_d[7:4] = bus.key_code;
            state_d  = A_LO;
         end
         A_LO: if (bus.key_valid) begin
            a_d[3:0] = bus.key_code;
            state_d  = B_HI;
         end
         B_HI: if (bus.key_valid) begin
            b_d[7:4] = bus.key_code;
            state_d  = B_LO;
         end
         B_LO: if (bus.key_valid) begin
            b_d[3:0] = bus.key_code;
            state_d  = CHECK;
         end
         CHECK: begin
            if (b_q == '0) begin
               err_d   = ERR_DIV0;
               state_d = ERR;
            end else if (is_ovf(a_q, b_q)) begin
               err_d   = ERR_OVF;
               state_d = ERR;
            end else begin
               state_d = START;
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            // Done takes priority over a simultaneous timeout.
            if (bus.div_done) begin
               q_d     = bus.div_q;
               r_d     = bus.div_r;
               state_d = SHOW;
            end else if (tmo_expired) begin
               err_d   = ERR_TMO;
               state_d = ERR;
            end
         end
         SHOW, ERR: if (bus.key_valid) begin
            a_d     = '0;
            b_d     = '0;
            err_d   = ERR_NONE;
            state_d = A_HI;
         end
         default: state_d = A_HI;
      endcase
   end

   // Display mux, decoded from the current state.
   always_comb begin
      bus.disp_val = {a_q, b_q};
      bus.disp_en  = 4'b1111;
      unique case (state_q)
         A_HI:    bus.disp_en = 4'b0000;
         A_LO:    bus.disp_en = 4'b1000;
         B_HI:    bus.disp_en = 4'b1100;
         B_LO:    bus.disp_en = 4'b1110;
         SHOW:    bus.disp_val = {1'b0, q_q, 1'b0, r_q};
         ERR:     bus.disp_val = {4'hE, 4'h0, 4'h0, 2'b00, err_q};
         default: ;
      endcase
   end

   assign bus.div_start    = start_q;
   assign bus.div_a        = a_q;
   assign bus.div_b        = b_q;
   assign bus.busy         = busy_q;
   assign bus.result_valid = rv_q;
   assign bus.err_code     = err_q;

endmodule

// File: tb/tb_div_entry_ctrl.sv
// Self-checking bench for div_entry_ctrl: vector table, corner sequences, random ops.
module tb_div_entry_ctrl;
   import div_ctrl_pkg::*;

   localparam int unsigned TO = 16;

   typedef struct {
      logic [15:0] keys;
      int          dly;   // WAIT cycle index of done; -1 = never
      logic [6:0]  q;
      logic [6:0]  r;
      logic [1:0]  err;
      logic [15:0] disp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[8];

   div_entry_ctrl_if bus ();

   div_entry_ctrl #(
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, " disp_val"}, bus.disp_val, 0);
      chk({name, " disp_en"}, bus.disp_en, 0);
      chk({name, " busy"}, bus.busy, 0);
      chk({name, " result_valid"}, bus.result_valid, 0);
      chk({name, " err_code"}, bus.err_code, 0);
      chk({name, " div_start"}, bus.div_start, 0);
      chk({name, " div_a"}, bus.div_a, 0);
      chk({name, " div_b"}, bus.div_b, 0);
   endtask

   // One-cycle key pulse; returns at the negedge after the sampling edge.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = k;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.key_code  = 4'($urandom);
   endtask

   task automatic enter_keys(input string name, input logic [15:0] keys);
      logic [15:0] mask;
      for (int i = 0; i < 4; i++) begin
         press(keys[15-4*i -: 4]);
         if (i < 3) begin
            mask = 16'hFFFF << (12 - 4 * i);
            chk({name, " entry disp_val"}, bus.disp_val, keys & mask);
            chk({name, " entry disp_en"}, bus.disp_en, 4'(4'b1111 << (3 - i)));
            chk({name, " entry busy"}, bus.busy, 0);
         end else begin
            chk({name, " check busy"}, bus.busy, 1);
            chk({name, " check disp_en"}, bus.disp_en, 4'b1111);
            chk({name, " check disp_val"}, bus.disp_val, keys);
            chk({name, " check div_start"}, bus.div_start, 0);
         end
      end
   endtask

   // Full operation: entry, screening, divider handshake, result, acknowledge.
   task automatic run_op(input string name, input logic [15:0] keys, input int dly,
                         input logic [6:0] q, input logic [6:0] r,
                         input logic [1:0] exp_err, input logic [15:0] exp_disp);
      bit sent;
      enter_keys(name, keys);
      @(negedge clk);
      if (exp_err == 2'd1 || exp_err == 2'd2) begin
         chk({name, " err_code"}, bus.err_code, exp_err);
         chk({name, " err disp_val"}, bus.disp_val, exp_disp);
         chk({name, " err no start"}, bus.div_start, 0);
         chk({name, " err busy"}, bus.busy, 0);
         chk({name, " err result_valid"}, bus.result_valid, 0);
      end else begin
         chk({name, " start pulse"}, bus.div_start, 1);
         chk({name, " div_a"}, bus.div_a, keys[15:8]);
         chk({name, " div_b"}, bus.div_b, keys[7:0]);
         @(negedge clk);
         chk({name, " start single"}, bus.div_start, 0);
         sent = 1'b0;
         for (int k = 0; k < int'(TO) && !sent; k++) begin
            chk({name, " wait busy"}, bus.busy, 1);
            chk({name, " wait result_valid"}, bus.result_valid, 0);
            if (k == dly) begin
               bus.div_done = 1'b1;
               bus.div_q    = q;
               bus.div_r    = r;
               sent         = 1'b1;
            end else begin
               bus.div_q = 7'($urandom);
               bus.div_r = 7'($urandom);
            end
            @(negedge clk);
            bus.div_done = 1'b0;
         end
         chk({name, " done result_valid"}, bus.result_valid, (exp_err == 2'd0));
         chk({name, " done err_code"}, bus.err_code, exp_err);
         chk({name, " done disp_val"}, bus.disp_val, exp_disp);
         chk({name, " done busy"}, bus.busy, 0);
      end
      press(4'($urandom));
      chk({name, " ack disp_en"}, bus.disp_en, 0);
      chk({name, " ack disp_val"}, bus.disp_val, 0);
      chk({name, " ack err_code"}, bus.err_code, 0);
      chk({name, " ack result_valid"}, bus.result_valid, 0);
   endtask

   initial begin
      int          a, b, dly, q, r;
      logic [1:0]  err;
      logic [15:0] disp;

      vecs[0] = '{16'h4507, 2,        7'd9,   7'd6,  2'd0, 16'h0906};
      vecs[1] = '{16'h1200, 0,        7'd0,   7'd0,  2'd1, 16'hE001};
      vecs[2] = '{16'hC801, 0,        7'd0,   7'd0,  2'd2, 16'hE002};
      vecs[3] = '{16'h80FF, 0,        7'd0,   7'd0,  2'd2, 16'hE002};
      vecs[4] = '{16'h4507, -1,       7'd0,   7'd0,  2'd3, 16'hE003};
      vecs[5] = '{16'h4507, TO - 1,   7'd9,   7'd6,  2'd0, 16'h0906};
      vecs[6] = '{16'hFF10, 5,        7'd15,  7'd15, 2'd0, 16'h0F0F};
      vecs[7] = '{16'h7F01, 1,        7'd127, 7'd0,  2'd0, 16'h7F00};

      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.div_done  = 1'b0;
      bus.div_q     = 7'h0;
      bus.div_r     = 7'h0;

      repeat (3) @(negedge clk);
      chk_zero("reset held");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("after reset");

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].keys, vecs[i].dly, vecs[i].q, vecs[i].r,
                vecs[i].err, vecs[i].disp);
      end

      // Stray done during entry and keys during WAIT are ignored.
      press(4'h4);
      @(negedge clk);
      bus.div_done = 1'b1;
      bus.div_q    = 7'h55;
      bus.div_r    = 7'h2A;
      @(negedge clk);
      bus.div_done = 1'b0;
      chk("stray done disp_en", bus.disp_en, 4'b1000);
      chk("stray done disp_val", bus.disp_val, 16'h4000);
      chk("stray done result_valid", bus.result_valid, 0);
      press(4'h5);
      press(4'h0);
      press(4'h7);
      @(negedge clk);
      @(negedge clk);
      chk("ignore wait busy", bus.busy, 1);
      press(4'hF);
      press(4'h3);
      chk("ignore div_a", bus.div_a, 8'h45);
      chk("ignore div_b", bus.div_b, 8'h07);
      chk("ignore disp_val", bus.disp_val, 16'h4507);
      chk("ignore still busy", bus.busy, 1);
      bus.div_done = 1'b1;
      bus.div_q    = 7'd9;
      bus.div_r    = 7'd6;
      @(negedge clk);
      bus.div_done = 1'b0;
      chk("ignore show valid", bus.result_valid, 1);
      chk("ignore show disp", bus.disp_val, 16'h0906);
      press(4'h2);
      chk("show ack disp_en", bus.disp_en, 0);
      chk("show ack err_code", bus.err_code, 0);
      chk("show ack key dropped", bus.disp_val, 0);

      // Reset after two nibbles.
      press(4'h4);
      press(4'h5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst entry");
      @(negedge clk);
      chk("rst entry no start", bus.div_start, 0);

      // Reset in the middle of WAIT.
      press(4'h4);
      press(4'h5);
      press(4'h0);
      press(4'h7);
      repeat (4) @(negedge clk);
      chk("pre-rst busy", bus.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst wait");
      @(negedge clk);
      chk("rst wait no start", bus.div_start, 0);
      run_op("post rst", 16'h4507, 3, 7'd9, 7'd6, 2'd0, 16'h0906);

      // Random operations against the arithmetic reference.
      for (int n = 0; n < 30; n++) begin
         a = int'($urandom_range(0, 255));
         case ($urandom_range(0, 9))
            0:       b = 0;
            1:       b = 1;
            2:       b = (a + 1) % 256;
            default: b = int'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 7) == 0)      dly = -1;
         else if ($urandom_range(0, 1) == 0) dly = int'($urandom_range(0, 3));
         else                                dly = int'($urandom_range(0, TO - 1));
         q = 0;
         r = 0;
         if (b == 0)                             err = 2'd1;
         else if (a >= 128 && (b == 1 || a < b)) err = 2'd2;
         else if (dly < 0)                       err = 2'd3;
         else begin
            err = 2'd0;
            q   = a / b;
            r   = a % b;
         end
         if (err != 2'd0) disp = {12'hE00, 2'b00, err};
         else             disp = {1'b0, 7'(q), 1'b0, 7'(r)};
         run_op($sformatf("rand%0d", n), {8'(a), 8'(b)}, dly, 7'(q), 7'(r), err, disp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
